// File: rtl/rx_buffer_ctrl.sv
// Receive/Received handshake sequencer with a FIFO for captured bytes,
// plus parity-error counting and sticky overflow tracking.
module rx_buffer_ctrl #(
  parameter int unsigned DEPTH    = 8,
  parameter bit          DROP_ERR = 1'b1,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       Receive,
  input  logic [7:0]                 Dout,
  input  logic                       parityErr,
  output logic                       Received,
  output logic [7:0]                 rdata,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [ERRCNT_W-1:0]        errCount,
  input  logic                       clrStatus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_CAPTURE = 2'd1,
    S_ACK     = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                received_q, received_d;
  logic                rvalid_q, rvalid_d;
  logic [CW-1:0]       count_q, count_d;
  logic [PW-1:0]       wptr_q, wptr_d;
  logic [PW-1:0]       rptr_q, rptr_d;
  logic                overflow_q, overflow_d;
  logic [ERRCNT_W-1:0] err_q, err_d;
  logic [7:0]          mem_q [DEPTH];

  logic                capture;
  logic                store;
  logic                pop;
  logic                room;
  logic                push;

  // Next-state, push/pop decision and status update
  always_comb begin
    state_d    = state_q;
    received_d = 1'b0;
    count_d    = count_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q;
    err_d      = err_q;

    case (state_q)
      S_WAIT:    if (Receive) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_ACK;
      S_ACK:     if (!Receive) state_d = S_WAIT;
      default:   state_d = S_WAIT;
    endcase
    received_d = (state_d == S_ACK);

    capture = (state_q == S_CAPTURE);
    store   = !(parityErr && DROP_ERR);
    pop     = rvalid_q && rready;
    // A simultaneous pop frees the slot the new byte needs
    room    = (count_q != CW'(DEPTH)) || pop;
    push    = capture && store && room;

    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    rvalid_d = (count_d != CW'(0));

    // Clear takes priority over any same-cycle set or increment
    if (clrStatus) begin
      overflow_d = 1'b0;
      err_d      = '0;
    end else begin
      if (capture && store && !room) overflow_d = 1'b1;
      if (capture && parityErr && (err_q != {ERRCNT_W{1'b1}})) err_d = err_q + ERRCNT_W'(1);
    end
  end

  // Control and status registers
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_WAIT;
      received_q <= 1'b0;
      rvalid_q   <= 1'b0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      received_q <= received_d;
      rvalid_q   <= rvalid_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= Dout;
  end

  assign Received = received_q;
  assign rvalid   = rvalid_q;
  assign rdata    = mem_q[rptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;
  assign errCount = err_q;

endmodule

// File: tb/tb_rx_buffer_ctrl.sv
// Directed bench for rx_buffer_ctrl: cycle table plus handshake sequences.
module tb_rx_buffer_ctrl;

  logic       clk = 1'b0;
  logic       Reset;
  logic       Receive;
  logic [7:0] Dout;
  logic       parityErr;
  logic       rready;
  logic       clrStatus;

  logic       Received, rvalid, overflow;
  logic [7:0] rdata, errCount;
  logic [3:0] count;

  logic       Received0, rvalid0, overflow0;
  logic [7:0] rdata0, errCount0;
  logic [3:0] count0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rx_buffer_ctrl #(.DEPTH(8), .DROP_ERR(1'b1), .ERRCNT_W(8)) u_dut (
    .clk(clk), .Reset(Reset), .Receive(Receive), .Dout(Dout), .parityErr(parityErr),
    .Received(Received), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .count(count), .overflow(overflow), .errCount(errCount), .clrStatus(clrStatus)
  );

  rx_buffer_ctrl #(.DEPTH(8), .DROP_ERR(1'b0), .ERRCNT_W(8)) u_dut0 (
    .clk(clk), .Reset(Reset), .Receive(Receive), .Dout(Dout), .parityErr(parityErr),
    .Received(Received0), .rdata(rdata0), .rvalid(rvalid0), .rready(rready),
    .count(count0), .overflow(overflow0), .errCount(errCount0), .clrStatus(clrStatus)
  );

  typedef struct {
    logic       rcv;
    logic [7:0] dout;
    logic       perr;
    logic       rdy;
    logic       clr;
    logic       exp_recvd;
    logic       exp_rvalid;
    logic [7:0] exp_rdata;
    logic [3:0] exp_count;
    logic       exp_ovf;
    logic [7:0] exp_err;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic vec_t mk(logic rcv, logic [7:0] d, logic pe, logic rdy, logic clr,
                              logic er, logic ev, logic [7:0] ed, logic [3:0] ec,
                              logic eo, logic [7:0] ee);
    vec_t v;
    v.rcv = rcv; v.dout = d; v.perr = pe; v.rdy = rdy; v.clr = clr;
    v.exp_recvd = er; v.exp_rvalid = ev; v.exp_rdata = ed; v.exp_count = ec;
    v.exp_ovf = eo; v.exp_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset = 1'b1; Receive = 1'b0; rready = 1'b0; clrStatus = 1'b0; parityErr = 1'b0;
    @(negedge clk);
    Reset = 1'b0;
  endtask

  // One full Receive pulse; rready/clrStatus only during the capture cycle
  task automatic send(input logic [7:0] d, input logic perr, input logic rdy_cap, input logic clr_cap);
    @(negedge clk);
    Receive = 1'b1; Dout = d; parityErr = perr; rready = 1'b0; clrStatus = 1'b0;
    @(negedge clk);
    rready = rdy_cap; clrStatus = clr_cap;
    @(negedge clk);
    Receive = 1'b0; rready = 1'b0; clrStatus = 1'b0;
    @(posedge clk); #1;
  endtask

  // Check head against expected byte, then pop it
  task automatic pop_expect(input string name, input logic [7:0] exp);
    @(negedge clk);
    check({name, " rvalid"}, rvalid, 1'b1);
    check({name, " rdata"}, rdata, exp);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    int q[$];
    Reset = 1'b1; Receive = 1'b0; Dout = 8'h00; parityErr = 1'b0;
    rready = 1'b0; clrStatus = 1'b0;

    // rcv dout perr rdy clr | recvd rvalid rdata count ovf err
    tbl[0]  = mk(1, 8'hA5, 0, 0, 0,  0, 0, 8'h00, 0, 0, 0);
    tbl[1]  = mk(1, 8'hA5, 0, 0, 0,  1, 1, 8'hA5, 1, 0, 0);
    tbl[2]  = mk(0, 8'h00, 0, 0, 0,  0, 1, 8'hA5, 1, 0, 0);
    tbl[3]  = mk(0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 0, 0, 0);
    tbl[4]  = mk(1, 8'h11, 0, 0, 0,  0, 0, 8'h00, 0, 0, 0);
    tbl[5]  = mk(1, 8'h11, 0, 0, 0,  1, 1, 8'h11, 1, 0, 0);
    tbl[6]  = mk(1, 8'h11, 0, 0, 0,  1, 1, 8'h11, 1, 0, 0);
    tbl[7]  = mk(1, 8'h11, 0, 0, 0,  1, 1, 8'h11, 1, 0, 0);
    tbl[8]  = mk(0, 8'h00, 0, 0, 0,  0, 1, 8'h11, 1, 0, 0);
    tbl[9]  = mk(1, 8'h22, 0, 0, 0,  0, 1, 8'h11, 1, 0, 0);
    tbl[10] = mk(1, 8'h22, 0, 0, 0,  1, 1, 8'h11, 2, 0, 0);
    tbl[11] = mk(0, 8'h00, 0, 0, 0,  0, 1, 8'h11, 2, 0, 0);
    tbl[12] = mk(1, 8'h33, 0, 0, 0,  0, 1, 8'h11, 2, 0, 0);
    tbl[13] = mk(1, 8'h33, 0, 0, 0,  1, 1, 8'h11, 3, 0, 0);
    tbl[14] = mk(0, 8'h00, 0, 0, 0,  0, 1, 8'h11, 3, 0, 0);
    tbl[15] = mk(0, 8'h00, 0, 1, 0,  0, 1, 8'h22, 2, 0, 0);
    tbl[16] = mk(0, 8'h00, 0, 1, 0,  0, 1, 8'h33, 1, 0, 0);
    tbl[17] = mk(0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 0, 0, 0);
    tbl[18] = mk(0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 0, 0, 0);
    tbl[19] = mk(1, 8'h5A, 1, 0, 0,  0, 0, 8'h00, 0, 0, 0);
    tbl[20] = mk(1, 8'h5A, 1, 0, 0,  1, 0, 8'h00, 0, 0, 1);
    tbl[21] = mk(0, 8'h00, 0, 0, 0,  0, 0, 8'h00, 0, 0, 1);
    tbl[22] = mk(0, 8'h00, 0, 0, 1,  0, 0, 8'h00, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset Received", Received, 1'b0);
    check("reset rvalid", rvalid, 1'b0);
    check("reset count", count, 4'd0);
    check("reset overflow", overflow, 1'b0);
    check("reset errCount", errCount, 8'h00);
    @(negedge clk);
    Reset = 1'b0;

    // Cycle-by-cycle table: handshake timing, ordering, parity drop
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      Receive = tbl[i].rcv; Dout = tbl[i].dout; parityErr = tbl[i].perr;
      rready = tbl[i].rdy; clrStatus = tbl[i].clr;
      @(posedge clk); #1;
      check($sformatf("row%0d Received", i), Received, tbl[i].exp_recvd);
      check($sformatf("row%0d rvalid", i), rvalid, tbl[i].exp_rvalid);
      if (tbl[i].exp_rvalid) check($sformatf("row%0d rdata", i), rdata, tbl[i].exp_rdata);
      check($sformatf("row%0d count", i), count, tbl[i].exp_count);
      check($sformatf("row%0d overflow", i), overflow, tbl[i].exp_ovf);
      check($sformatf("row%0d errCount", i), errCount, tbl[i].exp_err);
      if (i == 20) begin
        check("keep_err count", count0, 4'd1);
        check("keep_err rvalid", rvalid0, 1'b1);
        check("keep_err rdata", rdata0, 8'h5A);
        check("keep_err errCount", errCount0, 8'h01);
      end
    end

    // Fill, overflow, then push with simultaneous pop at full
    do_reset();
    for (int b = 1; b <= 8; b++) send(8'(b), 1'b0, 1'b0, 1'b0);
    check("full count", count, 4'd8);
    send(8'hFF, 1'b0, 1'b0, 1'b0);
    check("ovf overflow", overflow, 1'b1);
    check("ovf count", count, 4'd8);
    check("ovf head", rdata, 8'h01);
    @(negedge clk); clrStatus = 1'b1;
    @(posedge clk); #1; clrStatus = 1'b0;
    check("clr overflow", overflow, 1'b0);
    send(8'hFF, 1'b0, 1'b1, 1'b0);
    check("full_pop overflow", overflow, 1'b0);
    check("full_pop count", count, 4'd8);
    for (int b = 2; b <= 8; b++) pop_expect($sformatf("drain%0d", b), 8'(b));
    pop_expect("drainFF", 8'hFF);
    check("drained count", count, 4'd0);
    check("drained rvalid", rvalid, 1'b0);

    // Pointer wrap with interleaved pops
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send(8'(i), 1'b0, 1'b0, 1'b0);
      q.push_back(i);
      check($sformatf("wrap%0d count", i), count, 32'(q.size()));
      if (i % 3 != 0) pop_expect($sformatf("wrap%0d", i), 8'(q.pop_front()));
    end
    while (q.size() > 0) pop_expect("wrap_tail", 8'(q.pop_front()));
    check("wrap overflow", overflow, 1'b0);

    // errCount saturation and clear priority
    for (int k = 0; k < 255; k++) send(8'(k), 1'b1, 1'b0, 1'b0);
    check("sat errCount", errCount, 8'hFF);
    check("sat count", count, 4'd0);
    send(8'h42, 1'b1, 1'b0, 1'b0);
    check("sat hold errCount", errCount, 8'hFF);
    send(8'h77, 1'b1, 1'b0, 1'b1);
    check("clr_wins errCount", errCount, 8'h00);
    send(8'h77, 1'b1, 1'b0, 1'b0);
    check("post_clr errCount", errCount, 8'h01);

    // Asynchronous reset in ACK with 3 bytes queued
    do_reset();
    send(8'h10, 1'b0, 1'b0, 1'b0);
    send(8'h20, 1'b0, 1'b0, 1'b0);
    @(negedge clk); Receive = 1'b1; Dout = 8'h30; parityErr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ack Received", Received, 1'b1);
    check("ack count", count, 4'd3);
    #2 Reset = 1'b1;
    #1;
    check("async Received", Received, 1'b0);
    check("async count", count, 4'd0);
    check("async rvalid", rvalid, 1'b0);
    Receive = 1'b0;
    @(negedge clk); Reset = 1'b0;
    send(8'hAB, 1'b0, 1'b0, 1'b0);
    check("post_rst count", count, 4'd1);
    check("post_rst rvalid", rvalid, 1'b1);
    check("post_rst rdata", rdata, 8'hAB);
    check("post_rst Received", Received, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
